// File: rtl/fp_shift_pkg.sv
// Shared types and constants for the FP mantissa alignment shifter and the
// FP add/sub control FSM that drives it.
package fp_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEF_WIDTH = 27;
  localparam int DEF_CNT_W = 5;

  // Whether the shift about to be applied with this remaining count is the final one.
  function automatic logic last_shift(input logic [DEF_CNT_W-1:0] count);
    return count == DEF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/shift_reg_lr.sv
// Loadable WIDTH-bit shift register: parallel load has priority, otherwise
// one-bit left/right shift with ser_in filling the vacated end.
module shift_reg_lr
  import fp_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (shift) begin
      if (dir == DIR_LEFT) begin
        q_d = {q_q[WIDTH-2:0], ser_in};
      end else begin
        q_d = {ser_in, q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_align_shifter.sv
// Multi-cycle mantissa alignment shifter: start/busy/done handshake, per-cycle
// enabled single-bit shifts, and sticky accumulation on right shifts.
module seq_align_shifter
  import fp_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] shamt,
  input  logic             dir,
  input  logic             ser_in,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             sticky,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             dir_q;
  logic             sticky_q;
  logic             busy_q;
  logic             done_q;

  logic             load_d;
  logic             shift_d;
  logic [WIDTH-1:0] data_q;

  assign load_d  = (state_q == IDLE) && start;
  assign shift_d = (state_q == SHIFT) && en;

  shift_reg_lr #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load_d),
    .load_data(load_data),
    .shift    (shift_d),
    .dir      (dir_q),
    .ser_in   (ser_in),
    .q        (data_q)
  );

  // done is a registered one-cycle pulse raised on every entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      dir_q    <= DIR_RIGHT;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q  <= shamt;
            dir_q    <= dir;
            sticky_q <= 1'b0;
            busy_q   <= 1'b1;
            if (shamt == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (en) begin
            count_q <= count_q - CNT_W'(1);
            if (dir_q == DIR_RIGHT) begin
              sticky_q <= sticky_q | data_q[0];
            end
            if (count_q == CNT_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign sticky   = sticky_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_align_shifter.sv
// Scoreboard bench for seq_align_shifter: driver pushes model results, a
// negedge monitor pops and compares whenever done is presented.
module tb_seq_align_shifter;

  localparam int W  = 27;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  load_data;
  logic [CW-1:0] shamt;
  logic          dir;
  logic          ser_in;
  logic          en;
  logic [W-1:0]  data_out;
  logic          sticky;
  logic          busy;
  logic          done;

  seq_align_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_data(load_data),
    .shamt    (shamt),
    .dir      (dir),
    .ser_in   (ser_in),
    .en       (en),
    .data_out (data_out),
    .sticky   (sticky),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         st;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the result of s single-bit shifts is a plain shift with fill,
  // and the sticky is the OR of every original bit that fell off bit 0.
  function automatic exp_t model(input logic [W-1:0] d, input int s, input logic dr,
                                 input logic f);
    exp_t        e;
    logic [63:0] all1;
    logic [63:0] dd;
    logic [63:0] r;
    all1 = (64'd1 << W) - 64'd1;
    dd   = {{(64-W){1'b0}}, d};
    if (dr == 1'b0) begin
      if (s >= W) begin
        r    = f ? all1 : 64'd0;
        e.st = |dd;
      end else begin
        r    = (dd >> s) | (f ? (all1 & ~(all1 >> s)) : 64'd0);
        e.st = |(dd & ((64'd1 << s) - 64'd1));
      end
    end else begin
      e.st = 1'b0;
      if (s >= W) r = f ? all1 : 64'd0;
      else        r = ((dd << s) | (f ? ((64'd1 << s) - 64'd1) : 64'd0)) & all1;
    end
    e.d   = r[W-1:0];
    e.cyc = 0;
    return e;
  endfunction

  // Driver: called #1 after a rising edge with the DUT in IDLE; returns #1
  // after the DONE->IDLE edge so transactions run back to back.
  task automatic issue(input logic [W-1:0] d, input int s, input logic dr, input logic f,
                       input int stall_at, input int stall_len, input bit rnd_en,
                       input bit junk);
    bit          es[$];
    int          sh;
    int          stalled;
    int unsigned a;
    exp_t        e;
    bit          b;
    sh = 0;
    stalled = 0;
    while (sh < s) begin
      if (rnd_en) b = ($urandom_range(3) != 0);
      else if (sh == stall_at && stalled < stall_len) begin
        b = 1'b0;
        stalled++;
      end else b = 1'b1;
      es.push_back(b);
      if (b) sh++;
    end
    start     = 1'b1;
    load_data = d;
    shamt     = CW'(s);
    dir       = dr;
    ser_in    = f;
    en        = 1'($urandom);
    @(posedge clk);
    #1;
    a     = cyc;
    e     = model(d, s, dr, f);
    e.cyc = a + es.size();
    sb.push_back(e);
    start = 1'b0;
    foreach (es[i]) begin
      en = es[i];
      if (junk) begin
        start     = 1'($urandom);
        load_data = W'($urandom);
        shamt     = CW'($urandom);
        dir       = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    // DONE cycle: a start here must not be accepted.
    en = 1'($urandom);
    if (junk) begin
      start     = 1'b1;
      load_data = W'($urandom);
      shamt     = CW'($urandom);
      dir       = 1'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  exp_t mon_e;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      chk("busy_with_done", {63'd0, busy}, 64'd1);
      if (prev_done) chk("done_one_cycle", 64'd1, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("data_out", {{(64-W){1'b0}}, data_out}, {{(64-W){1'b0}}, mon_e.d});
        chk("sticky", {63'd0, sticky}, {63'd0, mon_e.st});
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    load_data = '0;
    shamt     = '0;
    dir       = 1'b0;
    ser_in    = 1'b0;
    en        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", {{(64-W){1'b0}}, data_out}, 64'd0);
    chk("rst_sticky", {63'd0, sticky}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a long right shift.
    start     = 1'b1;
    load_data = 27'h5A5A5A5;
    shamt     = 5'd20;
    dir       = 1'b0;
    en        = 1'b1;
    ser_in    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", {{(64-W){1'b0}}, data_out}, 64'd0);
    chk("arst_sticky", {63'd0, sticky}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_data", {{(64-W){1'b0}}, data_out}, 64'd0);

    // Directed cases
    issue(27'h4000001, 3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    issue(27'h0000001, 26, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    issue(27'h3C0FFEE, 0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    issue(27'h12345AB, 5, 1'b0, 1'b0, 99, 0, 1'b0, 1'b0);
    issue(27'h12345AB, 5, 1'b0, 1'b0, 2, 3, 1'b0, 1'b0);
    issue(27'h2A5F00D, 7, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
    issue(27'h0F0F0F1, 4, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    issue(27'h7FFFFFF, 31, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    issue(27'h7FFFFFF, 31, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    // data_out holds its value in IDLE after completion
    repeat (2) @(posedge clk);
    #1;
    chk("hold_idle", {{(64-W){1'b0}}, data_out}, 64'd0);
    chk("hold_sticky", {63'd0, sticky}, 64'd1);

    // Randomised transactions
    for (int n = 0; n < 40; n++) begin
      issue(W'($urandom), int'($urandom_range(31)), 1'($urandom), 1'($urandom),
            0, 0, 1'b1, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
